// File: rtl/segre_main_memory_pkg.sv
// Shared types and constants for the main-memory responder: request latch layout,
// FSM states, and the byte-enable / store-lane helpers.
package segre_main_memory_pkg;

  localparam int ADDR_SIZE        = 32;
  localparam int WORD_SIZE        = 32;
  localparam int DCACHE_LANE_SIZE = 128;
  localparam int LANE_BYTES       = DCACHE_LANE_SIZE / 8;
  localparam int LANE_OFF         = $clog2(LANE_BYTES);
  localparam int MM_LATENCY       = 5;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } memop_data_type_e;

  typedef enum logic [1:0] {
    MM_IDLE,
    MM_BUSY,
    MM_RESP
  } mm_state_e;

  typedef struct packed {
    logic                 wr;
    logic [ADDR_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] data;
    memop_data_type_e     dtype;
  } mm_req_t;

  // HALF ignores bit 0 and WORD ignores both offset bits, which is the align-down.
  function automatic logic [3:0] mm_byte_en(input memop_data_type_e t, input logic [1:0] off);
    case (t)
      BYTE:    mm_byte_en = 4'b0001 << off;
      HALF:    mm_byte_en = off[1] ? 4'b1100 : 4'b0011;
      default: mm_byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [WORD_SIZE-1:0] mm_wr_lanes(input memop_data_type_e t,
                                                       input logic [WORD_SIZE-1:0] d);
    case (t)
      BYTE:    mm_wr_lanes = {4{d[7:0]}};
      HALF:    mm_wr_lanes = {2{d[15:0]}};
      default: mm_wr_lanes = d;
    endcase
  endfunction

endpackage

// File: rtl/segre_main_memory_if.sv
// Core-to-memory request bus: the core MMU is the master, the memory model the slave.
interface segre_main_memory_if;
  import segre_main_memory_pkg::*;

  logic                        rd_i;
  logic                        wr_i;
  logic [ADDR_SIZE-1:0]        addr_i;
  logic [WORD_SIZE-1:0]        wr_data_i;
  memop_data_type_e            wr_data_type_i;
  logic                        data_rdy_o;
  logic [DCACHE_LANE_SIZE-1:0] rd_data_o;

  modport master (
    output rd_i, wr_i, addr_i, wr_data_i, wr_data_type_i,
    input  data_rdy_o, rd_data_o
  );

  modport slave (
    input  rd_i, wr_i, addr_i, wr_data_i, wr_data_type_i,
    output data_rdy_o, rd_data_o
  );
endinterface

// File: rtl/segre_mm_byte_array.sv
// Byte-addressed storage: one registered lane-wide read port and one word write port
// with per-byte enables. Contents are never reset; only the read register is.
module segre_mm_byte_array
  import segre_main_memory_pkg::*;
#(
  parameter int    MEM_BYTES = 65536,
  parameter int    NUM_BYTES = LANE_BYTES,
  parameter string INIT_FILE = ""
) (
  input  logic                                      clk_i,
  input  logic                                      rsn_i,
  input  logic                                      re,
  input  logic [$clog2(MEM_BYTES)-$clog2(NUM_BYTES)-1:0] raddr,
  output logic [NUM_BYTES*8-1:0]                    rdata,
  input  logic                                      we,
  input  logic [$clog2(MEM_BYTES)-3:0]              waddr,
  input  logic [31:0]                               wdata,
  input  logic [3:0]                                be
);
  localparam int LO = $clog2(NUM_BYTES);

  logic [7:0] mem [MEM_BYTES];

  always_ff @(posedge clk_i) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[{waddr, 2'(i)}] <= wdata[8*i +: 8];
      end
    end
  end

  // Holds the last lane read; writes never touch it.
  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      rdata <= '0;
    end else if (re) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        rdata[8*i +: 8] <= mem[{raddr, LO'(i)}];
      end
    end
  end

endmodule

// File: rtl/segre_main_memory.sv
// Fixed-latency main-memory responder: latches one request, counts down, performs the
// access on the last busy cycle and pulses data_rdy_o for one cycle.
module segre_main_memory
  import segre_main_memory_pkg::*;
#(
  parameter int    MEM_BYTES = 65536,
  parameter int    LATENCY   = MM_LATENCY,
  parameter string INIT_FILE = ""
) (
  input logic                clk_i,
  input logic                rsn_i,
  segre_main_memory_if.slave mm
);
  localparam int AW = $clog2(MEM_BYTES);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  mm_state_e       state;
  logic [CW-1:0]   cnt;
  mm_req_t         req;
  logic            data_rdy;
  logic [AW-1:0]   eff;
  logic            fire, we, re;
  logic [3:0]      be;
  logic [31:0]     wdata;
  logic            unused_addr_hi;

  // Upper address bits simply wrap the address space.
  assign eff            = req.addr[AW-1:0];
  assign unused_addr_hi = ^req.addr[ADDR_SIZE-1:AW];

  assign fire  = (state == MM_BUSY) && (cnt == '0);
  assign we    = fire & req.wr & rsn_i;
  assign re    = fire & ~req.wr & rsn_i;
  assign be    = mm_byte_en(req.dtype, eff[1:0]);
  assign wdata = mm_wr_lanes(req.dtype, req.data);

  assign mm.data_rdy_o = data_rdy;

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      state    <= MM_IDLE;
      cnt      <= '0;
      data_rdy <= 1'b0;
      req      <= '0;
    end else begin
      data_rdy <= 1'b0;
      case (state)
        MM_IDLE: begin
          if (mm.rd_i | mm.wr_i) begin
            // A write wins over a simultaneous read.
            req   <= '{wr: mm.wr_i, addr: mm.addr_i, data: mm.wr_data_i, dtype: mm.wr_data_type_i};
            cnt   <= CNT_INIT;
            state <= MM_BUSY;
          end
        end
        MM_BUSY: begin
          if (cnt == '0) begin
            state    <= MM_RESP;
            data_rdy <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        MM_RESP: state <= MM_IDLE;
        default: state <= MM_IDLE;
      endcase
    end
  end

  segre_mm_byte_array #(
    .MEM_BYTES (MEM_BYTES),
    .NUM_BYTES (LANE_BYTES),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk_i (clk_i),
    .rsn_i (rsn_i),
    .re    (re),
    .raddr (eff[AW-1:LANE_OFF]),
    .rdata (mm.rd_data_o),
    .we    (we),
    .waddr (eff[AW-1:2]),
    .wdata (wdata),
    .be    (be)
  );

endmodule

// File: tb/tb_segre_main_memory.sv
// Directed bench for the main-memory responder: latency, lane reads, sub-word writes,
// held requests, rd/wr collision, reset mid-operation and address wrap.
module tb_segre_main_memory;
  import segre_main_memory_pkg::*;

  localparam int LAT = 5;

  logic clk = 1'b0;
  logic rsn = 1'b0;
  int   passed = 0;
  int   total  = 0;

  segre_main_memory_if mm_if ();

  segre_main_memory #(
    .MEM_BYTES (65536),
    .LATENCY   (LAT),
    .INIT_FILE ("")
  ) dut (
    .clk_i (clk),
    .rsn_i (rsn),
    .mm    (mm_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issues one request, drops it in the response cycle and watches 20 cycles.
  // lat = posedges from accept to pulse (-1 if none), pulses = total pulses seen.
  task automatic xact(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input memop_data_type_e t, output int lat, output int pulses);
    mm_if.rd_i = r; mm_if.wr_i = w; mm_if.addr_i = a;
    mm_if.wr_data_i = d; mm_if.wr_data_type_i = t;
    lat = -1; pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (mm_if.data_rdy_o) begin
        pulses++;
        if (lat < 0) begin
          lat = k - 1;
          mm_if.rd_i = 1'b0; mm_if.wr_i = 1'b0;
        end
      end
    end
    mm_if.rd_i = 1'b0; mm_if.wr_i = 1'b0;
  endtask

  task automatic test_reset();
    int pulses = 0;
    rsn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (mm_if.data_rdy_o !== 1'b0) $display("FAIL reset_rdy: got %b want 0", mm_if.data_rdy_o);
    else passed++;
    total++;
    if (mm_if.rd_data_o !== 128'h0) $display("FAIL reset_rdata: got %h want 0", mm_if.rd_data_o);
    else passed++;
    rsn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (mm_if.data_rdy_o) pulses++;
    end
    total++;
    if (pulses !== 0) $display("FAIL idle_no_pulse: got %0d pulses want 0", pulses);
    else passed++;
  endtask

  task automatic test_word_lane_read();
    int lat, pulses;
    xact(0, 1, 32'h100, 32'h01020304, WORD, lat, pulses);
    xact(0, 1, 32'h104, 32'hDEADBEEF, WORD, lat, pulses);
    total++;
    if (lat !== LAT) $display("FAIL wr_latency: got %0d want %0d", lat, LAT);
    else passed++;
    total++;
    if (pulses !== 1) $display("FAIL wr_pulses: got %0d want 1", pulses);
    else passed++;
    xact(0, 1, 32'h108, 32'h0A0B0C0D, WORD, lat, pulses);
    xact(0, 1, 32'h10C, 32'h55667788, WORD, lat, pulses);
    xact(0, 1, 32'h110, 32'hFFFFFFFF, WORD, lat, pulses);
    xact(1, 0, 32'h10C, 32'h0, WORD, lat, pulses);
    total++;
    if (lat !== LAT) $display("FAIL rd_latency: got %0d want %0d", lat, LAT);
    else passed++;
    total++;
    if (mm_if.rd_data_o[63:32] !== 32'hDEADBEEF)
      $display("FAIL rd_word1: got %h want deadbeef", mm_if.rd_data_o[63:32]);
    else passed++;
    total++;
    if (mm_if.rd_data_o !== 128'h55667788_0A0B0C0D_DEADBEEF_01020304)
      $display("FAIL rd_lane: got %h want 556677880a0b0c0ddeadbeef01020304", mm_if.rd_data_o);
    else passed++;
  endtask

  task automatic test_subword();
    int lat, pulses;
    logic [127:0] prev;
    xact(0, 1, 32'h200, 32'h77665544, WORD, lat, pulses);
    prev = mm_if.rd_data_o;
    xact(0, 1, 32'h201, 32'hFFFFFFAA, BYTE, lat, pulses);
    total++;
    if (mm_if.rd_data_o !== prev) $display("FAIL wr_keeps_rdata: got %h want %h", mm_if.rd_data_o, prev);
    else passed++;
    xact(0, 1, 32'h203, 32'hABCD1234, HALF, lat, pulses);
    xact(1, 0, 32'h200, 32'h0, WORD, lat, pulses);
    total++;
    if (mm_if.rd_data_o[31:0] !== 32'h1234AA44)
      $display("FAIL subword: got %h want 1234aa44", mm_if.rd_data_o[31:0]);
    else passed++;
  endtask

  task automatic test_held_request();
    int pulses = 0, k1 = -1, k2 = -1;
    mm_if.addr_i = 32'h200; mm_if.wr_data_type_i = WORD; mm_if.rd_i = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (mm_if.data_rdy_o) begin pulses++; if (k1 < 0) k1 = k; end
      if (k1 > 0 && k == k1 + 1) mm_if.rd_i = 1'b0;
    end
    mm_if.rd_i = 1'b0;
    total++;
    if (pulses !== 1) $display("FAIL held_single: got %0d pulses want 1", pulses);
    else passed++;
    pulses = 0; k1 = -1;
    mm_if.rd_i = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk); #1;
      if (mm_if.data_rdy_o) begin
        pulses++;
        if (k1 < 0) k1 = k; else if (k2 < 0) k2 = k;
      end
      if (k1 > 0 && k == k1 + 4) mm_if.rd_i = 1'b0;
    end
    mm_if.rd_i = 1'b0;
    total++;
    if (pulses !== 2) $display("FAIL held_double: got %0d pulses want 2", pulses);
    else passed++;
    // Idle cycles between the end of the first pulse and the start of the second.
    total++;
    if (k2 - k1 - 1 !== LAT + 1) $display("FAIL held_gap: got %0d want %0d", k2 - k1 - 1, LAT + 1);
    else passed++;
  endtask

  task automatic test_rd_wr_collision();
    int lat, pulses;
    logic [127:0] prev;
    prev = mm_if.rd_data_o;
    xact(1, 1, 32'h300, 32'h00000055, BYTE, lat, pulses);
    total++;
    if (pulses !== 1) $display("FAIL collide_pulses: got %0d want 1", pulses);
    else passed++;
    total++;
    if (mm_if.rd_data_o !== prev) $display("FAIL collide_rdata: got %h want %h", mm_if.rd_data_o, prev);
    else passed++;
    xact(1, 0, 32'h300, 32'h0, WORD, lat, pulses);
    total++;
    if (mm_if.rd_data_o[7:0] !== 8'h55) $display("FAIL collide_write: got %h want 55", mm_if.rd_data_o[7:0]);
    else passed++;
  endtask

  task automatic test_reset_mid_op();
    int lat, pulses = 0;
    xact(0, 1, 32'h400, 32'h11223344, WORD, lat, pulses);
    pulses = 0;
    mm_if.wr_i = 1'b1; mm_if.addr_i = 32'h400;
    mm_if.wr_data_i = 32'h99999999; mm_if.wr_data_type_i = WORD;
    repeat (2) begin
      @(posedge clk); #1;
      if (mm_if.data_rdy_o) pulses++;
    end
    rsn = 1'b0; mm_if.wr_i = 1'b0;
    @(posedge clk); #1;
    rsn = 1'b1;
    total++;
    if (mm_if.rd_data_o !== 128'h0) $display("FAIL midrst_rdata: got %h want 0", mm_if.rd_data_o);
    else passed++;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (mm_if.data_rdy_o) pulses++;
    end
    total++;
    if (pulses !== 0) $display("FAIL midrst_pulse: got %0d pulses want 0", pulses);
    else passed++;
    xact(1, 0, 32'h400, 32'h0, WORD, lat, pulses);
    total++;
    if (mm_if.rd_data_o[31:0] !== 32'h11223344)
      $display("FAIL midrst_mem: got %h want 11223344", mm_if.rd_data_o[31:0]);
    else passed++;
  endtask

  task automatic test_addr_wrap();
    int lat, pulses;
    xact(0, 1, 32'h00010008, 32'hCAFEF00D, WORD, lat, pulses);
    xact(1, 0, 32'h00000000, 32'h0, WORD, lat, pulses);
    total++;
    if (mm_if.rd_data_o[95:64] !== 32'hCAFEF00D)
      $display("FAIL wrap_low: got %h want cafef00d", mm_if.rd_data_o[95:64]);
    else passed++;
    xact(0, 1, 32'h00000004, 32'h0BADC0DE, WORD, lat, pulses);
    xact(1, 0, 32'h00010000, 32'h0, WORD, lat, pulses);
    total++;
    if (mm_if.rd_data_o[95:32] !== 64'hCAFEF00D_0BADC0DE)
      $display("FAIL wrap_high: got %h want cafef00d0badc0de", mm_if.rd_data_o[95:32]);
    else passed++;
  endtask

  initial begin
    mm_if.rd_i = 1'b0; mm_if.wr_i = 1'b0; mm_if.addr_i = '0;
    mm_if.wr_data_i = '0; mm_if.wr_data_type_i = WORD;
    test_reset();
    test_word_lane_read();
    test_subword();
    test_held_request();
    test_rd_wr_collision();
    test_reset_mid_op();
    test_addr_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
